// File: rtl/stage4_twiddle_seq.sv
// Stage-4 twiddle sequencer: tags each complex sample with its frame index k and
// pairs it with the angle -k*pi/8 read from an external registered ROM.
module stage4_twiddle_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2*DATA_W-1:0]   i_data,
    input  logic                  i_sof,
    output logic [ADDR_W-1:0]     o_rom_addr,
    input  logic [DATA_W-1:0]     i_rom_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*DATA_W-1:0]   o_data,
    output logic [DATA_W-1:0]     o_angle,
    output logic [ADDR_W-1:0]     o_index,
    output logic                  o_last,
    output logic                  o_sync_err
);

    logic                v1;
    logic [2*DATA_W-1:0] data1;
    logic [ADDR_W-1:0]   idx1;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   idx_new;
    logic                accept;
    logic                s1_adv;

    assign s1_adv  = v1 && (!o_valid || i_ready);
    assign o_ready = i_rst || !v1 || s1_adv;
    assign accept  = i_valid && o_ready && !i_rst;
    assign idx_new = i_sof ? '0 : cnt;

    // The ROM is addressed one cycle ahead so its registered output lines up
    // with the S1 -> S2 transfer; while S1 stalls it keeps re-reading idx1.
    assign o_rom_addr = i_rst ? '0 : (accept ? idx_new : idx1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1         <= 1'b0;
            data1      <= '0;
            idx1       <= '0;
            cnt        <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_angle    <= '0;
            o_index    <= '0;
            o_last     <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            if (accept) begin
                v1    <= 1'b1;
                data1 <= i_data;
                idx1  <= idx_new;
                cnt   <= idx_new + ADDR_W'(1);
                if (i_sof && (cnt != '0)) begin
                    o_sync_err <= 1'b1;
                end
            end else if (s1_adv) begin
                v1 <= 1'b0;
            end

            if (s1_adv) begin
                o_valid <= 1'b1;
                o_data  <= data1;
                o_angle <= i_rom_data;
                o_index <= idx1;
                o_last  <= &idx1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
